// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, frame geometry and baud divisor helper.
// Imported by the transmitter and, later, the receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      START = 3'd2,
      DATA  = 3'd3,
      STOP  = 3'd4
   } uart_tx_state_t;

   localparam int UART_DATA_BITS = 8;

   // Integer clocks per bit; the fraction is dropped, matching the baud counter's wrap point.
   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle of each bit.
// Held at zero when disabled so an idle link never free-runs.
module uart_baud_counter #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic bit_end
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] count_r;

   assign bit_end = en && (count_r == CNT_LAST);

   // Bit-period counter with wrap at the bit boundary.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_r <= {CNT_W{1'b0}};
      end else if (clear || !en) begin
         count_r <= {CNT_W{1'b0}};
      end else if (count_r == CNT_LAST) begin
         count_r <= {CNT_W{1'b0}};
      end else begin
         count_r <= count_r + CNT_W'(1);
      end
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter that drains bytes from a FIFO with a registered data_out.
// One FIFO read per frame, issued only from IDLE; the byte is captured in the following FETCH cycle.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 100_000_000,
   parameter int BAUD_RATE = 115200
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [UART_DATA_BITS-1:0] fifo_data,
   input  logic                      fifo_empty,
   output logic                      fifo_rd_en,
   output logic                      tx,
   output logic                      busy,
   output logic                      tx_done
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);

   if (CLKS_PER_BIT < 2) begin : g_cpb_check
      $error("uart_tx: CLKS_PER_BIT must be at least 2");
   end

   uart_tx_state_t            state_r, state_s;
   logic [UART_DATA_BITS-1:0] shift_r, shift_s;
   logic [2:0]                bit_idx_r, bit_idx_s;
   logic                      tx_r, tx_s;
   logic                      tx_done_r, tx_done_s;
   logic                      rd_en_s;
   logic                      bit_end_s;
   logic                      baud_en_s;
   logic                      baud_clear_s;

   assign baud_en_s    = (state_r == START) || (state_r == DATA) || (state_r == STOP);
   assign baud_clear_s = (state_r == FETCH);

   uart_baud_counter #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk    (clk),
      .reset  (reset),
      .clear  (baud_clear_s),
      .en     (baud_en_s),
      .bit_end(bit_end_s)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Frame datapath registers; tx is registered so the line never glitches.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_r   <= {UART_DATA_BITS{1'b0}};
         bit_idx_r <= 3'd0;
         tx_r      <= 1'b1;
         tx_done_r <= 1'b0;
      end else begin
         shift_r   <= shift_s;
         bit_idx_r <= bit_idx_s;
         tx_r      <= tx_s;
         tx_done_r <= tx_done_s;
      end
   end

   // Next-state and next-datapath logic.
   always_comb begin
      state_s   = state_r;
      shift_s   = shift_r;
      bit_idx_s = bit_idx_r;
      tx_s      = tx_r;
      tx_done_s = 1'b0;
      rd_en_s   = 1'b0;
      case (state_r)
         IDLE: begin
            tx_s = 1'b1;
            // Reset gating keeps the read strobe quiet while the link is held in reset.
            if (!fifo_empty && !reset) begin
               rd_en_s = 1'b1;
               state_s = FETCH;
            end else begin
               state_s = IDLE;
            end
         end
         FETCH: begin
            shift_s   = fifo_data;
            bit_idx_s = 3'd0;
            tx_s      = 1'b0;
            state_s   = START;
         end
         START: begin
            if (bit_end_s) begin
               tx_s    = shift_r[0];
               state_s = DATA;
            end else begin
               tx_s = 1'b0;
            end
         end
         DATA: begin
            if (bit_end_s) begin
               shift_s   = {1'b0, shift_r[UART_DATA_BITS-1:1]};
               bit_idx_s = bit_idx_r + 3'd1;
               if (bit_idx_r == 3'd7) begin
                  tx_s    = 1'b1;
                  state_s = STOP;
               end else begin
                  tx_s = shift_r[1];
               end
            end else begin
               tx_s = tx_r;
            end
         end
         STOP: begin
            tx_s = 1'b1;
            if (bit_end_s) begin
               tx_done_s = 1'b1;
               state_s   = IDLE;
            end else begin
               state_s = STOP;
            end
         end
         default: begin
            tx_s    = 1'b1;
            state_s = IDLE;
         end
      endcase
   end

   assign fifo_rd_en = rd_en_s;
   assign tx         = tx_r;
   assign tx_done    = tx_done_r;
   assign busy       = (state_r != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at CLKS_PER_BIT=4 with a behavioural 16-deep FIFO source.
// Expected line levels come from the frame definition: start at 0, data LSB first, stop at 1.
module tb_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 16;

   logic       clk        = 1'b0;
   logic       reset      = 1'b1;
   logic [7:0] fifo_data  = 8'h00;
   logic       fifo_empty = 1'b1;
   logic       fifo_rd_en;
   logic       tx;
   logic       busy;
   logic       tx_done;

   logic       push_v = 1'b0;
   logic [7:0] push_d = 8'h00;
   logic [7:0] fifo_q[$];

   int n_assert = 0;
   int n_fail   = 0;

   uart_tx #(
      .CLK_FREQ (400),
      .BAUD_RATE(100)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .fifo_data (fifo_data),
      .fifo_empty(fifo_empty),
      .fifo_rd_en(fifo_rd_en),
      .tx        (tx),
      .busy      (busy),
      .tx_done   (tx_done)
   );

   always #5 clk = ~clk;

   // FIFO model: registered data_out and empty, both updated on the accepting edge.
   always @(posedge clk) begin
      if (fifo_rd_en && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
      if (push_v && fifo_q.size() < DEPTH) fifo_q.push_back(push_d);
      fifo_empty <= (fifo_q.size() == 0);
   end

   task automatic chk1(input string tag, input logic got, input logic exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, got, exp);
      end
   endtask

   task automatic chk32(input string tag, input int got, input int exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   // Line level j cycles after the read-strobe cycle: j=1 is the fetch cycle (idle high),
   // then ten bit slots of CPB cycles each.
   function automatic logic exp_tx(input logic [7:0] b, input int j);
      int k;
      if (j < 2) return 1'b1;
      k = (j - 2) / CPB;
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      return 1'b1;
   endfunction

   task automatic push(input logic [7:0] d);
      push_d = d;
      push_v = 1'b1;
      @(negedge clk);
      push_v = 1'b0;
   endtask

   task automatic wait_rd(input string tag);
      int n = 0;
      while (!fifo_rd_en && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk1({tag, "_rd_en_seen"}, fifo_rd_en, 1'b1);
   endtask

   // Starts at the negedge of the read-strobe cycle and ends at the negedge of the tx_done cycle.
   task automatic frame(input logic [7:0] b, input logic next, input logic chk_empty);
      for (int j = 1; j <= 10 * CPB + 2; j++) begin
         @(negedge clk);
         if (j <= 10 * CPB + 1) begin
            chk1($sformatf("tx_%02h_c%0d", b, j), tx, exp_tx(b, j));
            chk1($sformatf("busy_%02h_c%0d", b, j), busy, 1'b1);
            chk1($sformatf("done_%02h_c%0d", b, j), tx_done, 1'b0);
            chk1($sformatf("rd_en_%02h_c%0d", b, j), fifo_rd_en, 1'b0);
         end else begin
            chk1($sformatf("tx_idle_%02h", b), tx, 1'b1);
            chk1($sformatf("busy_end_%02h", b), busy, 1'b0);
            chk1($sformatf("done_pulse_%02h", b), tx_done, 1'b1);
            chk1($sformatf("rd_en_next_%02h", b), fifo_rd_en, next);
         end
         if (j == 1 && chk_empty) chk1("empty_after_fetch", fifo_empty, 1'b1);
      end
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk1({tag, "_tx"}, tx, 1'b1);
         chk1({tag, "_busy"}, busy, 1'b0);
         chk1({tag, "_done"}, tx_done, 1'b0);
         chk1({tag, "_rd_en"}, fifo_rd_en, 1'b0);
      end
   endtask

   logic [7:0] drain_bytes[DEPTH];
   logic [7:0] rb;

   initial begin
      // Reset and idle with an empty FIFO.
      idle(5, "in_reset");
      reset = 1'b0;
      idle(100, "idle_after_reset");

      // Single byte 0x55.
      push(8'h55);
      wait_rd("b55");
      frame(8'h55, 1'b0, 1'b1);
      idle(5, "after_55");

      // Back-to-back: both bytes queued, released together.
      reset = 1'b1;
      push(8'hA5);
      push(8'h3C);
      reset = 1'b0;
      #1;
      chk1("rd_en_first_after_reset", fifo_rd_en, 1'b1);
      frame(8'hA5, 1'b1, 1'b0);
      frame(8'h3C, 1'b0, 1'b1);
      idle(5, "after_b2b");

      // Extremes.
      push(8'h00);
      wait_rd("b00");
      frame(8'h00, 1'b0, 1'b1);
      idle(3, "after_00");
      push(8'hFF);
      wait_rd("bFF");
      frame(8'hFF, 1'b0, 1'b1);
      idle(3, "after_FF");

      // Random bytes.
      for (int i = 0; i < 6; i++) begin
         rb = 8'($urandom_range(0, 255));
         push(rb);
         wait_rd("rand");
         frame(rb, 1'b0, 1'b1);
         idle(2, "after_rand");
      end

      // Reset in the middle of data bit 3 of 0xF0.
      push(8'hF0);
      wait_rd("bF0");
      repeat (2 + 4 * CPB + 1) @(negedge clk);
      chk1("tx_F0_bit3_before_reset", tx, 1'b0);
      reset = 1'b1;
      #1;
      chk1("tx_async_reset", tx, 1'b1);
      chk1("busy_async_reset", busy, 1'b0);
      chk1("rd_en_async_reset", fifo_rd_en, 1'b0);
      @(negedge clk);
      chk1("done_in_reset", tx_done, 1'b0);
      reset = 1'b0;
      idle(10, "no_reread");
      chk32("fifo_count_before_81", fifo_q.size(), 0);
      push(8'h81);
      chk32("fifo_count_after_push_81", fifo_q.size(), 1);
      wait_rd("b81");
      frame(8'h81, 1'b0, 1'b1);
      chk32("fifo_count_after_81", fifo_q.size(), 0);
      idle(3, "after_81");

      // Fill the FIFO while held in reset, then drain all 16 bytes.
      reset = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         drain_bytes[i] = 8'($urandom_range(0, 255));
         push(drain_bytes[i]);
      end
      chk32("fifo_full_count", fifo_q.size(), DEPTH);
      reset = 1'b0;
      #1;
      chk1("drain_rd_en_first", fifo_rd_en, 1'b1);
      for (int i = 0; i < DEPTH; i++) begin
         frame(drain_bytes[i], (i < DEPTH - 1) ? 1'b1 : 1'b0, (i == DEPTH - 1) ? 1'b1 : 1'b0);
      end
      idle(20, "after_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmit engine for the host link: drains bytes from a transmit-side `uart_fifo` instance, fed by the command parser's response path, and shifts each out on the `tx` pin as an 8N1 UART frame. It is the outbound counterpart of the receive chain (UART receiver → FIFO → command parser). It acts as the FIFO's only reader, using the FIFO's `read_en`/`empty`/`data_out` handshake, where `data_out` is registered and updates on the clock edge that accepts `read_en`.

## Interface
- `CLK_FREQ`, default 100_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 115200: line rate in baud.
- `CLKS_PER_BIT` (localparam): `CLK_FREQ / BAUD_RATE`, truncated; must be ≥ 2 (elaboration-time assertion).
- `clk` input, 1 bit: system clock.
- `reset` input, 1 bit: one clock; reset is asynchronous and active-high.
- `fifo_data` input, 8 bits: FIFO `data_out`.
- `fifo_empty` input, 1 bit: FIFO `empty`.
- `fifo_rd_en` output, 1 bit: FIFO `read_en`; combinational.
- `tx` output, 1 bit: serial line, idle high; registered.
- `busy` output, 1 bit: high whenever state ≠ IDLE.
- `tx_done` output, 1 bit: one-cycle pulse at the end of each stop bit; registered.

## Operation
- States are IDLE, FETCH, START, DATA and STOP.
- **IDLE**
  - `tx`=1.
  - `fifo_rd_en = (state==IDLE) && !fifo_empty`.
  - When `fifo_rd_en` is high, the next state is FETCH.
- **FETCH** (1 cycle)
  - `fifo_data` is now valid; capture it into an 8-bit shift register.
  - Clear the baud counter and bit index, drive `tx`←0, and go to START.
- **START**: `tx`=0 for `CLKS_PER_BIT` cycles, then `tx`←shift[0] and go to DATA.
- **DATA**
  - Bits are sent LSB first, each held for `CLKS_PER_BIT` cycles.
  - At each bit end, shift right and increment the bit index.
  - After bit 7, `tx`←1 and go to STOP.
- **STOP**: `tx`=1 for `CLKS_PER_BIT` cycles; at the end, pulse `tx_done` and return to IDLE.
- Baud counter
  - Width is `$clog2(CLKS_PER_BIT)`.
  - Counts 0 … `CLKS_PER_BIT`-1 and wraps to 0 at each bit boundary. It never free-runs in IDLE and is held at 0 there.
- Bit index is 3 bits and wraps naturally; the DATA exit is detected when index==7 at a bit end.
- The block never asserts `fifo_rd_en` outside IDLE, so exactly one FIFO read happens per frame and the FIFO cannot be over-read.
- Reset (asynchronous, any state)
  - State returns to IDLE and `tx` goes to 1 immediately.
  - `tx_done`, the counters and the shift register return to 0.
  - A frame in flight is truncated; its byte is lost and is not re-read.
  - Reset values: `tx`=1, `busy`=0, `tx_done`=0, `fifo_rd_en`=0.

## Timing
- Cycle T: IDLE with `fifo_empty`=0, so `fifo_rd_en`=1 during T.
- Cycle T+1: FETCH.
- Start bit occupies cycles T+2 … T+1+`CLKS_PER_BIT`.
- Frame length on the line is exactly 10·`CLKS_PER_BIT` cycles: start, 8 data, stop.
- `tx_done` is high in the first cycle after the stop bit, which is the IDLE cycle. In that cycle `fifo_rd_en` may already be high for the next byte.
- Back-to-back bytes: 2 idle-high cycles (IDLE + FETCH) between the stop bit of one frame and the start bit of the next.
- `fifo_empty` rising while the block is not in IDLE has no effect.
- Reset deassertion: the first possible `fifo_rd_en` is in the first cycle after reset falls.

## Structure
- Shared package `uart_pkg` holds:
  - `uart_tx_state_t` enum (IDLE, FETCH, START, DATA, STOP);
  - `UART_DATA_BITS` = 8;
  - a `clks_per_bit(clk_freq, baud)` function, for reuse by the receiver.
- Sub-module `uart_baud_counter`
  - Parameters: `CLKS_PER_BIT`. Inputs: `clear`, `en`. Output: `bit_end` pulse.
  - The receiver can share it later.
- The FIFO is external; the top level instantiates `uart_fifo` with `DEPTH`=16, `WIDTH`=8 and wires it to this block.

## Test plan
All scenarios use `CLK_FREQ`=400, `BAUD_RATE`=100, so `CLKS_PER_BIT`=4, with a real `uart_fifo` model as the source.
- **Reset/idle:** with reset asserted, and after release with the FIFO empty, `tx`=1, `busy`=0, `fifo_rd_en`=0 and `tx_done`=0 for ≥100 cycles.
- **Single byte:** push 0x55.
  - Exactly one `fifo_rd_en` pulse, then `tx` low 2 cycles after the pulse cycle for 4 cycles.
  - Data bits 1,0,1,0,1,0,1,0 at 4 cycles each, then stop high for 4 cycles.
  - One `tx_done` pulse; `busy` high for 41 cycles.
- **Back-to-back:** push 0xA5 then 0x3C.
  - Two frames decode to 0xA5 and 0x3C, with exactly 2 high cycles between the stop bit and the next start bit.
  - Two `rd_en` pulses and two `tx_done` pulses.
- **Extremes:** 0x00 gives 36 low cycles, then 4 high. 0xFF gives 4 low, then 36 high. Bit order is checked LSB first.
- **Reset mid-frame:**
  - Push 0xF0 and assert reset during data bit 3; `tx`=1 in the same cycle (asynchronous), `busy`=0.
  - After release, push 0x81; the frame is correct and the FIFO count decrements by exactly 1.
- **FIFO drain:** push 16 bytes (FIFO full).
  - All 16 are transmitted in order, with no `rd_en` while empty.
  - `empty` is high after the 16th FETCH, and the line is idle-high afterwards.
